// File: rtl/lc3_control_mw_pkg.sv
// Shared types and encodings for the memory-handshake LC-3 control FSM.
// Covers control states, opcodes, datapath mux encodings and small decode helpers.
package lc3_control_mw_pkg;

  typedef enum logic [4:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_BR0, S_ALU0,
    S_LD0, S_LDR0, S_LD1, S_LD2, S_LDI2, S_LDI3,
    S_ST0, S_ST1, S_STR1, S_ST_W, S_STI0, S_STI1, S_STI2,
    S_JSR0, S_JSR1, S_JMP0, S_LEA0,
    S_TRAP0, S_TRAP1, S_TRAP2, S_TRAP3
  } ctrl_state_e;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [1:0] ALU_PASSA = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_NOT   = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_EAB = 2'b01;
  localparam logic [1:0] PC_BUS = 2'b10;

  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  localparam logic MDR_BUS  = 1'b0;
  localparam logic MDR_MEM  = 1'b1;
  localparam logic MAR_ZEXT = 1'b1;
  localparam logic EAB1_SR1 = 1'b1;

  // States that hold a memory access open until mem_rdy
  function automatic logic is_mem_state(ctrl_state_e s);
    return (s == S_FETCH1) || (s == S_LD1) || (s == S_LDI3) || (s == S_ST_W) ||
           (s == S_STI1) || (s == S_LDI1_ALIAS(s)) || (s == S_TRAP2);
  endfunction

  function automatic ctrl_state_e S_LDI1_ALIAS(ctrl_state_e s);
    // LDI's first read shares the LD1 state, so the alias maps to LD1
    return (s == S_LD1) ? S_LD1 : S_TRAP2;
  endfunction

  function automatic logic branch_en(logic [2:0] mask, logic n, logic z, logic p);
    return (mask[2] & n) | (mask[1] & z) | (mask[0] & p);
  endfunction

endpackage

// File: rtl/lc3_control_mw_if.sv
// Controller-to-datapath/memory signal bundle; master is the control FSM.
interface lc3_control_mw_if;
  logic [15:0] IR;
  logic        N, Z, P;
  logic        mem_rdy;
  logic        mem_req, memWE;
  logic [1:0]  aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic        regWE, flagWE;
  logic        enaALU, enaPC, enaMDR, enaMARM;
  logic [1:0]  selPC;
  logic        selMAR, selEAB1;
  logic [1:0]  selEAB2;
  logic        selMDR;
  logic        ldPC, ldIR, ldMAR, ldMDR;
  logic        bus_err, ill_op, instr_done;

  modport master (
    input  IR, N, Z, P, mem_rdy,
    output mem_req, memWE, aluControl, SR1, SR2, DR, regWE, flagWE,
           enaALU, enaPC, enaMDR, enaMARM, selPC, selMAR, selEAB1, selEAB2,
           selMDR, ldPC, ldIR, ldMAR, ldMDR, bus_err, ill_op, instr_done
  );

  modport slave (
    output IR, N, Z, P, mem_rdy,
    input  mem_req, memWE, aluControl, SR1, SR2, DR, regWE, flagWE,
           enaALU, enaPC, enaMDR, enaMARM, selPC, selMAR, selEAB1, selEAB2,
           selMDR, ldPC, ldIR, ldMAR, ldMDR, bus_err, ill_op, instr_done
  );
endinterface

// File: rtl/lc3_control_mw_mem_wait.sv
// Memory wait counter: counts stalled cycles of one access and flags the abort cycle.
module lc3_mem_wait #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_rdy,
  input  logic state_change,
  output logic timeout
);
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (state_change || mem_rdy || !mem_req) ? '0 : cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A zero limit disables the abort entirely
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_tmo
      assign timeout = 1'b0;
    end else begin : g_tmo
      assign timeout = mem_req && !mem_rdy && (cnt_q == TMO_W'(MEM_TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/lc3_control_mw.sv
// Multi-cycle LC-3 control FSM with mem_req/mem_rdy handshake, bus timeout,
// illegal-opcode pulse and retire pulse; outputs decode combinationally from state.
module lc3_control_mw
  import lc3_control_mw_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1),
  parameter bit FLAGS_ON_LD = 1'b1
) (
  input logic clk,
  input logic rst,
  lc3_control_mw_if.master cif
);
  ctrl_state_e state_q, state_d;
  logic        mem_req_w, timeout_w, state_change_w;
  logic [3:0]  opcode;
  logic        rdy;

  logic       mem_we, reg_we, flag_we, ena_alu, ena_pc, ena_mdr, ena_marm;
  logic [1:0] alu_ctl, sel_pc, sel_eab2;
  logic [2:0] sr1, sr2, dr;
  logic       sel_mar, sel_eab1, sel_mdr, ld_pc, ld_ir, ld_mar, ld_mdr;
  logic       bus_err, ill_op, instr_done;

  assign opcode         = cif.IR[15:12];
  assign rdy            = cif.mem_rdy;
  assign mem_req_w      = rst && is_mem_state(state_q);
  assign state_change_w = (state_d != state_q);

  lc3_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_wait (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req_w),
    .mem_rdy      (rdy),
    .state_change (state_change_w),
    .timeout      (timeout_w)
  );

  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;  alu_ctl  = ALU_PASSA;
    sr1        = '0;    sr2      = '0;   dr      = '0;
    reg_we     = 1'b0;  flag_we  = 1'b0;
    ena_alu    = 1'b0;  ena_pc   = 1'b0; ena_mdr = 1'b0; ena_marm = 1'b0;
    sel_pc     = PC_INC; sel_mar = 1'b0; sel_eab1 = 1'b0; sel_eab2 = EAB2_ZERO;
    sel_mdr    = MDR_BUS;
    ld_pc      = 1'b0;  ld_ir    = 1'b0; ld_mar  = 1'b0; ld_mdr   = 1'b0;
    bus_err    = 1'b0;  ill_op   = 1'b0; instr_done = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH0: begin ena_pc = 1'b1; ld_mar = 1'b1; state_d = S_FETCH1; end
        S_FETCH1: begin
          sel_mdr = MDR_MEM; ld_mdr = rdy; ld_pc = rdy; sel_pc = PC_INC;
          state_d = S_FETCH2;
        end
        S_FETCH2: begin ena_mdr = 1'b1; ld_ir = 1'b1; state_d = S_DECODE; end
        S_DECODE: begin
          case (opcode)
            OP_BR:                  state_d = S_BR0;
            OP_ADD, OP_AND, OP_NOT: state_d = S_ALU0;
            OP_LD, OP_LDI:          state_d = S_LD0;
            OP_LDR:                 state_d = S_LDR0;
            OP_ST, OP_STR:          state_d = S_ST0;
            OP_STI:                 state_d = S_STI0;
            OP_JSR:                 state_d = S_JSR0;
            OP_JMP:                 state_d = S_JMP0;
            OP_LEA:                 state_d = S_LEA0;
            OP_TRAP:                state_d = S_TRAP0;
            default: begin ill_op = 1'b1; state_d = S_FETCH0; end
          endcase
        end
        S_BR0: begin
          sel_eab2 = EAB2_OFF9; sel_pc = PC_EAB;
          ld_pc = branch_en(cif.IR[11:9], cif.N, cif.Z, cif.P);
          instr_done = 1'b1; state_d = S_FETCH0;
        end
        S_ALU0: begin
          case (opcode)
            OP_ADD:  alu_ctl = ALU_ADD;
            OP_AND:  alu_ctl = ALU_AND;
            default: alu_ctl = ALU_NOT;
          endcase
          sr1 = cif.IR[8:6]; sr2 = cif.IR[2:0]; dr = cif.IR[11:9];
          reg_we = 1'b1; flag_we = 1'b1; ena_alu = 1'b1;
          instr_done = 1'b1; state_d = S_FETCH0;
        end
        S_LD0, S_ST1, S_STI0: begin
          ena_marm = 1'b1; sel_eab2 = EAB2_OFF9; ld_mar = 1'b1;
          state_d = (state_q == S_LD0) ? S_LD1 : (state_q == S_ST1) ? S_ST_W : S_STI1;
        end
        S_LDR0, S_STR1: begin
          ena_marm = 1'b1; sel_eab1 = EAB1_SR1; sr1 = cif.IR[8:6];
          sel_eab2 = EAB2_OFF6; ld_mar = 1'b1;
          state_d = (state_q == S_LDR0) ? S_LD1 : S_ST_W;
        end
        S_LD1, S_LDI3, S_STI1, S_TRAP2: begin
          sel_mdr = MDR_MEM; ld_mdr = rdy;
          case (state_q)
            S_LD1:   state_d = (opcode == OP_LDI) ? S_LDI2 : S_LD2;
            S_LDI3:  state_d = S_LD2;
            S_STI1:  state_d = S_STI2;
            default: state_d = S_TRAP3;
          endcase
        end
        S_LDI2, S_STI2: begin
          ena_mdr = 1'b1; ld_mar = 1'b1;
          state_d = (state_q == S_LDI2) ? S_LDI3 : S_ST0;
        end
        S_LD2: begin
          ena_mdr = 1'b1; dr = cif.IR[11:9]; reg_we = 1'b1; flag_we = FLAGS_ON_LD;
          instr_done = 1'b1; state_d = S_FETCH0;
        end
        S_ST0: begin
          sr1 = cif.IR[11:9]; alu_ctl = ALU_PASSA; ena_alu = 1'b1;
          sel_mdr = MDR_BUS; ld_mdr = 1'b1;
          case (opcode)
            OP_ST:   state_d = S_ST1;
            OP_STR:  state_d = S_STR1;
            default: state_d = S_ST_W;
          endcase
        end
        S_ST_W: begin mem_we = 1'b1; instr_done = rdy; state_d = S_FETCH0; end
        S_JSR0, S_TRAP0: begin
          ena_pc = 1'b1; dr = 3'd7; reg_we = 1'b1;
          state_d = (state_q == S_JSR0) ? S_JSR1 : S_TRAP1;
        end
        S_JSR1: begin
          sel_pc = PC_EAB; ld_pc = 1'b1; instr_done = 1'b1; state_d = S_FETCH0;
          if (cif.IR[11]) sel_eab2 = EAB2_OFF11;
          else begin sel_eab1 = EAB1_SR1; sr1 = cif.IR[8:6]; end
        end
        S_JMP0: begin
          sr1 = cif.IR[8:6]; sel_eab1 = EAB1_SR1; sel_pc = PC_EAB; ld_pc = 1'b1;
          instr_done = 1'b1; state_d = S_FETCH0;
        end
        S_LEA0: begin
          ena_marm = 1'b1; sel_eab2 = EAB2_OFF9; dr = cif.IR[11:9];
          reg_we = 1'b1; flag_we = FLAGS_ON_LD; instr_done = 1'b1; state_d = S_FETCH0;
        end
        S_TRAP1: begin sel_mar = MAR_ZEXT; ena_marm = 1'b1; ld_mar = 1'b1; state_d = S_TRAP2; end
        S_TRAP3: begin
          ena_mdr = 1'b1; sel_pc = PC_BUS; ld_pc = 1'b1; instr_done = 1'b1; state_d = S_FETCH0;
        end
        default: state_d = S_FETCH0;
      endcase
      // A stalled access holds its state; the abort cycle discards the access
      if (mem_req_w && !rdy) begin
        bus_err = timeout_w;
        state_d = timeout_w ? S_FETCH0 : state_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH0;
    else      state_q <= state_d;
  end

  assign cif.mem_req    = mem_req_w;
  assign cif.memWE      = mem_we;
  assign cif.aluControl = alu_ctl;
  assign cif.SR1        = sr1;
  assign cif.SR2        = sr2;
  assign cif.DR         = dr;
  assign cif.regWE      = reg_we;
  assign cif.flagWE     = flag_we;
  assign cif.enaALU     = ena_alu;
  assign cif.enaPC      = ena_pc;
  assign cif.enaMDR     = ena_mdr;
  assign cif.enaMARM    = ena_marm;
  assign cif.selPC      = sel_pc;
  assign cif.selMAR     = sel_mar;
  assign cif.selEAB1    = sel_eab1;
  assign cif.selEAB2    = sel_eab2;
  assign cif.selMDR     = sel_mdr;
  assign cif.ldPC       = ld_pc;
  assign cif.ldIR       = ld_ir;
  assign cif.ldMAR      = ld_mar;
  assign cif.ldMDR      = ld_mdr;
  assign cif.bus_err    = bus_err;
  assign cif.ill_op     = ill_op;
  assign cif.instr_done = instr_done;
endmodule

// File: tb/tb_lc3_control_mw.sv
// Bench: per-instruction micro-step model with randomized mem_rdy and IR stimulus.
module tb_lc3_control_mw;
  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req, memWE;
    logic [1:0] alu;
    logic [2:0] sr1, sr2, dr;
    logic       regWE, flagWE, enaALU, enaPC, enaMDR, enaMARM;
    logic [1:0] selPC;
    logic       selMAR, selEAB1;
    logic [1:0] selEAB2;
    logic       selMDR, ldPC, ldIR, ldMAR, ldMDR, bus_err, ill_op, instr_done;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic mem, rd, fe, wr, term;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc3_control_mw_if cif();
  lc3_control_mw #(.MEM_TIMEOUT(TMO), .FLAGS_ON_LD(1'b1)) dut (.clk(clk), .rst(rst), .cif(cif));

  ctl_t dut_c;
  assign dut_c = {cif.mem_req, cif.memWE, cif.aluControl, cif.SR1, cif.SR2, cif.DR,
                  cif.regWE, cif.flagWE, cif.enaALU, cif.enaPC, cif.enaMDR, cif.enaMARM,
                  cif.selPC, cif.selMAR, cif.selEAB1, cif.selEAB2, cif.selMDR,
                  cif.ldPC, cif.ldIR, cif.ldMAR, cif.ldMDR, cif.bus_err, cif.ill_op,
                  cif.instr_done};

  int errors = 0, checks = 0;
  step_t steps[$];
  bit rdy_q[$];
  logic [15:0] cur_ir;
  int cur_step;
  ctl_t last_c;
  int n_memreq, n_ldmar, n_ldmdr, n_ldpc, n_memwe, n_we_bad, n_buserr, n_done, n_ill, n_regwe;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cmp_ctl(input string name, input ctl_t want);
    checks++;
    if (dut_c !== want) begin
      errors++;
      $display("FAIL %s ir=%h step=%0d got=%h want=%h", name, cur_ir, cur_step, dut_c, want);
    end
  endtask

  function automatic void push(ctl_t c, logic mem, logic rd, logic fe, logic wr, logic term);
    steps.push_back({c, mem, rd, fe, wr, term});
  endfunction

  function automatic ctl_t mar_pc9();
    ctl_t c = '0; c.enaMARM = 1; c.selEAB2 = 2'b10; c.ldMAR = 1; return c;
  endfunction
  function automatic ctl_t mar_sr6(logic [15:0] ir);
    ctl_t c = '0; c.enaMARM = 1; c.selEAB1 = 1; c.sr1 = ir[8:6]; c.selEAB2 = 2'b01; c.ldMAR = 1;
    return c;
  endfunction
  function automatic ctl_t mdr2mar();
    ctl_t c = '0; c.enaMDR = 1; c.ldMAR = 1; return c;
  endfunction
  function automatic ctl_t st0(logic [15:0] ir);
    ctl_t c = '0; c.sr1 = ir[11:9]; c.enaALU = 1; c.ldMDR = 1; return c;
  endfunction
  function automatic ctl_t ld_wb(logic [15:0] ir);
    ctl_t c = '0; c.enaMDR = 1; c.dr = ir[11:9]; c.regWE = 1; c.flagWE = 1; c.instr_done = 1;
    return c;
  endfunction

  // Expected cycle-by-cycle control sequence of one instruction, from the ISA description
  function automatic void build(logic [15:0] ir, logic [2:0] nzp);
    ctl_t c;
    logic [3:0] op = ir[15:12];
    logic be = |(ir[11:9] & nzp);
    steps.delete();
    c = '0; c.enaPC = 1; c.ldMAR = 1; push(c, 0, 0, 0, 0, 0);
    push('0, 1, 1, 1, 0, 0);
    c = '0; c.enaMDR = 1; c.ldIR = 1; push(c, 0, 0, 0, 0, 0);
    c = '0; c.ill_op = (op == 4'h8 || op == 4'hD); push(c, 0, 0, 0, 0, 0);
    case (op)
      4'h0: begin
        c = '0; c.selEAB2 = 2'b10; c.selPC = 2'b01; c.ldPC = be; c.instr_done = 1;
        push(c, 0, 0, 0, 0, 0);
      end
      4'h1, 4'h5, 4'h9: begin
        c = '0; c.alu = (op == 4'h1) ? 2'd1 : (op == 4'h5) ? 2'd2 : 2'd3;
        c.sr1 = ir[8:6]; c.sr2 = ir[2:0]; c.dr = ir[11:9];
        c.regWE = 1; c.flagWE = 1; c.enaALU = 1; c.instr_done = 1;
        push(c, 0, 0, 0, 0, 0);
      end
      4'h2, 4'h6: begin
        push((op == 4'h2) ? mar_pc9() : mar_sr6(ir), 0, 0, 0, 0, 0);
        push('0, 1, 1, 0, 0, 0);
        push(ld_wb(ir), 0, 0, 0, 0, 0);
      end
      4'hA: begin
        push(mar_pc9(), 0, 0, 0, 0, 0); push('0, 1, 1, 0, 0, 0);
        push(mdr2mar(), 0, 0, 0, 0, 0); push('0, 1, 1, 0, 0, 0);
        push(ld_wb(ir), 0, 0, 0, 0, 0);
      end
      4'h3, 4'h7: begin
        push(st0(ir), 0, 0, 0, 0, 0);
        push((op == 4'h3) ? mar_pc9() : mar_sr6(ir), 0, 0, 0, 0, 0);
        push('0, 1, 0, 0, 1, 1);
      end
      4'hB: begin
        push(mar_pc9(), 0, 0, 0, 0, 0); push('0, 1, 1, 0, 0, 0);
        push(mdr2mar(), 0, 0, 0, 0, 0); push(st0(ir), 0, 0, 0, 0, 0);
        push('0, 1, 0, 0, 1, 1);
      end
      4'h4: begin
        c = '0; c.enaPC = 1; c.dr = 3'd7; c.regWE = 1; push(c, 0, 0, 0, 0, 0);
        c = '0; c.selPC = 2'b01; c.ldPC = 1; c.instr_done = 1;
        if (ir[11]) c.selEAB2 = 2'b11;
        else begin c.selEAB1 = 1; c.sr1 = ir[8:6]; end
        push(c, 0, 0, 0, 0, 0);
      end
      4'hC: begin
        c = '0; c.sr1 = ir[8:6]; c.selEAB1 = 1; c.selPC = 2'b01; c.ldPC = 1; c.instr_done = 1;
        push(c, 0, 0, 0, 0, 0);
      end
      4'hE: begin
        c = '0; c.enaMARM = 1; c.selEAB2 = 2'b10; c.dr = ir[11:9]; c.regWE = 1; c.flagWE = 1;
        c.instr_done = 1; push(c, 0, 0, 0, 0, 0);
      end
      4'hF: begin
        c = '0; c.enaPC = 1; c.dr = 3'd7; c.regWE = 1; push(c, 0, 0, 0, 0, 0);
        c = '0; c.selMAR = 1; c.enaMARM = 1; c.ldMAR = 1; push(c, 0, 0, 0, 0, 0);
        push('0, 1, 1, 0, 0, 0);
        c = '0; c.enaMDR = 1; c.selPC = 2'b10; c.ldPC = 1; c.instr_done = 1;
        push(c, 0, 0, 0, 0, 0);
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH0; entered and left at posedge+1
  task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp, input int pct,
                           input int rst_step, output int cycles);
    int i = 0, wcnt = 0;
    bit rdy, tmo;
    step_t s;
    ctl_t ex;
    build(ir, nzp);
    cur_ir = ir; cycles = 0;
    {n_memreq, n_ldmar, n_ldmdr, n_ldpc, n_memwe, n_we_bad} = '0;
    {n_buserr, n_done, n_ill, n_regwe} = '0;
    cif.IR = ir; {cif.N, cif.Z, cif.P} = nzp;
    while (i < steps.size()) begin
      rdy = (rdy_q.size() > 0) ? rdy_q.pop_front() : ($urandom_range(0, 99) < pct);
      cif.mem_rdy = rdy;
      cur_step = i;
      if (i == rst_step) begin
        rst = 1'b0;
        repeat (2) begin
          @(negedge clk); cmp_ctl("rst_zero", '0);
          @(posedge clk); #1; cif.mem_rdy = $urandom_range(0, 1);
        end
        rst = 1'b1;
        return;
      end
      @(negedge clk);
      s = steps[i];
      tmo = s.mem && !rdy && (wcnt == TMO - 1);
      ex = s.c;
      if (s.mem) begin
        ex.mem_req = 1;
        if (s.rd) begin ex.selMDR = 1; ex.ldMDR = rdy; end
        if (s.fe) ex.ldPC = rdy;
        if (s.wr) ex.memWE = 1;
        if (s.term) ex.instr_done = rdy;
        ex.bus_err = tmo;
      end
      cmp_ctl("ctl", ex);
      last_c = dut_c;
      n_memreq += int'(dut_c.mem_req); n_ldmar += int'(dut_c.ldMAR);
      n_ldmdr += int'(dut_c.ldMDR && dut_c.selMDR); n_ldpc += int'(dut_c.ldPC);
      n_memwe += int'(dut_c.memWE); n_we_bad += int'(dut_c.memWE && !dut_c.mem_req);
      n_buserr += int'(dut_c.bus_err); n_done += int'(dut_c.instr_done);
      n_ill += int'(dut_c.ill_op); n_regwe += int'(dut_c.regWE);
      cycles++;
      @(posedge clk); #1;
      if (cycles > 500) begin
        check("cycle_budget", cycles, 500);
        return;
      end
      if (s.mem && !rdy) begin
        if (tmo) return;
        wcnt++;
      end else begin
        wcnt = 0; i++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] r;
    cif.IR = '0; cif.N = 0; cif.Z = 0; cif.P = 0; cif.mem_rdy = 1'b1;
    repeat (3) begin @(negedge clk); cur_ir = '0; cur_step = -1; cmp_ctl("reset_zero", '0); end
    @(posedge clk); #1; rst = 1'b1;

    run_instr(16'h1283, 3'b000, 100, -1, cyc);
    check("add_cycles", cyc, 5);
    check("add_sr1", int'(last_c.sr1), 2);
    check("add_sr2", int'(last_c.sr2), 3);
    check("add_dr", int'(last_c.dr), 1);
    check("add_we_flags_done", int'({last_c.regWE, last_c.flagWE, last_c.instr_done}), 7);

    rdy_q = '{1, 0, 0, 0, 1};
    run_instr(16'h1283, 3'b000, 100, -1, cyc);
    check("fetch_wait_memreq", n_memreq, 4);
    check("fetch_wait_ldmdr", n_ldmdr, 1);
    check("fetch_wait_ldpc", n_ldpc, 1);
    check("fetch_wait_buserr", n_buserr, 0);

    rdy_q = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    run_instr(16'h2205, 3'b000, 100, -1, cyc);
    check("tmo_buserr", n_buserr, 1);
    check("tmo_regwe", n_regwe, 0);
    check("tmo_done", n_done, 0);
    check("tmo_cycles", cyc, 9);
    run_instr(16'h1283, 3'b000, 100, -1, cyc);
    check("after_tmo_cycles", cyc, 5);

    run_instr(16'h0405, 3'b100, 100, -1, cyc);
    check("brz_notaken_ldpc", int'(last_c.ldPC), 0);
    run_instr(16'h0405, 3'b010, 100, -1, cyc);
    check("brz_taken_ldpc", int'(last_c.ldPC), 1);
    check("brz_taken_selpc", int'(last_c.selPC), 1);
    check("brz_taken_seleab2", int'(last_c.selEAB2), 2);

    run_instr(16'h2205, 3'b000, 100, -1, cyc); check("ld_cycles", cyc, 7);
    run_instr(16'hA205, 3'b000, 100, -1, cyc); check("ldi_cycles", cyc, 9);
    run_instr(16'h3205, 3'b000, 100, -1, cyc); check("st_cycles", cyc, 7);
    run_instr(16'hF025, 3'b000, 100, -1, cyc); check("trap_cycles", cyc, 8);

    rdy_q = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
    run_instr(16'hB602, 3'b000, 100, -1, cyc);
    check("sti_cycles", cyc, 15);
    check("sti_ldmar", n_ldmar, 3);
    check("sti_memwe", n_memwe, 3);
    check("sti_memwe_wo_req", n_we_bad, 0);
    check("sti_done", n_done, 1);

    run_instr(16'hD000, 3'b000, 100, -1, cyc);
    check("ill_pulse", n_ill, 1);
    check("ill_cycles", cyc, 4);
    run_instr(16'h8000, 3'b000, 100, -1, cyc);
    check("rti_pulse", n_ill, 1);

    run_instr(16'hF025, 3'b000, 50, 6, cyc);
    run_instr(16'h1283, 3'b000, 100, -1, cyc);
    check("after_rst_cycles", cyc, 5);

    for (int k = 0; k < 250; k++) begin
      r = $urandom();
      run_instr(r[15:0], r[18:16], 65, (k % 23 == 7) ? int'(r[21:19]) : -1, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc3_control_mw.md
Name: lc3_control_mw

Overview:
- Next-generation multi-cycle LC-3 control FSM. Adds a variable-latency memory handshake (mem_req/mem_rdy), a parametrised bus-timeout, illegal-opcode reporting and an instruction-retire pulse.
- Drives the same datapath controls as the current controller (tristate enables, register loads, mux selects, write enables).
- Sits between IR/NZP flags and the datapath plus memory interface.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory access before abort. 0 = wait forever.
- TMO_W, $clog2(MEM_TIMEOUT+1): width of the wait counter.
- FLAGS_ON_LD, 1: when 1, flagWE is asserted on LD/LDR/LDI/LEA register writes (ISA-correct). When 0, only ADD/AND/NOT set flags.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- IR  in  16  instruction register
- N, Z, P  in  1 each  condition flags
- mem_rdy  in  1  memory completes current access this cycle
- mem_req  out  1  memory access in progress
- memWE  out  1  access is a write (valid with mem_req)
- aluControl  out  2  00 passA, 01 ADD, 10 AND, 11 NOT
- SR1, SR2, DR  out  3 each  register-file addresses
- regWE, flagWE  out  1 each
- enaALU, enaPC, enaMDR, enaMARM  out  1 each  bus drivers, at most one high
- selPC  out  2  00 PC+1, 01 EAB, 10 bus
- selMAR  out  1  0 EAB, 1 zext(IR[7:0])
- selEAB1  out  1  0 PC, 1 SR1
- selEAB2  out  2  00 zero, 01 off6, 10 off9, 11 off11
- selMDR  out  1  0 bus, 1 memory
- ldPC, ldIR, ldMAR, ldMDR  out  1 each
- bus_err  out  1  one-cycle pulse on memory timeout
- ill_op  out  1  one-cycle pulse on RTI/reserved opcode
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- State is registered and the output decode is combinational from state, IR, flags and mem_rdy.
- While rst==0 at a clock edge: state <= FETCH0, wait counter <= 0. Outputs are forced to all-zero while rst is low.
- branch_enable = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
- Memory states are FETCH1, LD1, LDI1, LDI3, ST_W, STI1, TRAP2. Each of these:
  - asserts mem_req (plus memWE in ST_W) every cycle until mem_rdy.
  - for reads, asserts selMDR=1 and ldMDR=mem_rdy.
  - in FETCH1 only, also asserts ldPC=mem_rdy with selPC=00.
  - advances only on mem_rdy.
- Wait counter: increments each cycle mem_req&!mem_rdy, and clears on mem_rdy or state change.
- If the counter reaches MEM_TIMEOUT-1 and mem_rdy is still 0: bus_err=1 that cycle, mem_req deasserted next cycle, next state FETCH0, no register/PC/flag writes.
- A mem_rdy arriving on the timeout cycle wins: the access completes and bus_err stays 0.
- Fetch and decode: FETCH0 (enaPC, ldMAR) -> FETCH1 -> FETCH2 (enaMDR, ldIR) -> DECODE.
- DECODE dispatches on IR[15:12]:
  - BR -> BR0: selEAB2=10, selPC=01, ldPC=branch_enable.
  - ADD/AND/NOT -> ALU0: SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9], regWE, flagWE, enaALU.
  - LD -> LD0: MAR<=PC+off9 -> LD1 -> LD2 (enaMDR, DR, regWE).
  - LDR -> LDR0: MAR<=SR1+off6 -> LD1.
  - LDI -> LD0 -> LD1 -> LDI2 (enaMDR, ldMAR) -> LDI3 -> LD2.
  - ST -> ST0 (SR1=IR[11:9] via ALU to MDR) -> ST1 (MAR<=PC+off9) -> ST_W.
  - STR -> ST0 -> STR1 (MAR<=SR1+off6) -> ST_W.
  - STI -> STI0 (MAR<=PC+off9) -> STI1 -> STI2 (enaMDR, ldMAR) -> ST0 -> ST_W.
  - JSR/JSRR (IR[11]): JSR0 (enaPC, DR=7, regWE) -> JSR1 (selPC=01; selEAB1/selEAB2 = 0/11 if IR[11], else 1/00 with SR1=IR[8:6]).
  - JMP/RET -> JMP0: SR1=IR[8:6], selEAB1=1, selPC=01, ldPC.
  - LEA -> LEA0: enaMARM, selEAB2=10, DR, regWE.
  - TRAP -> TRAP0 (R7<=PC) -> TRAP1 (selMAR=1, enaMARM, ldMAR) -> TRAP2 -> TRAP3 (enaMDR, selPC=10, ldPC).
  - RTI/reserved -> ill_op pulse in DECODE, next state FETCH0.
- flagWE follows FLAGS_ON_LD in LD2 and LEA0.
- instr_done is high in the terminal state (BR0, ALU0, LD2, ST_W on mem_rdy, JSR1, JMP0, LEA0, TRAP3) and never on abort.
- Latency with mem_rdy tied high:
  - ADD: 5 cycles
  - LD: 7 cycles
  - LDI: 9 cycles
  - ST: 7 cycles
  - TRAP: 8 cycles
- Reset mid-access: mem_req drops combinationally, and the FSM restarts at FETCH0 after release.

Decomposition:
- lc3Pkg gets:
  - an extended ControlStates enum with the new states
  - opcode constants
  - encodings for aluControl, selPC, selEAB2 and selMDR as localparams
- One sub-module, lc3_mem_wait: the wait counter and timeout compare. Inputs are clk, rst, mem_req, mem_rdy and state_change; output is timeout.

Test Plan:
- ADD R1,R2,R3 (0x1283), mem_rdy=1 -> ALU0 in cycle 5: SR1=2, SR2=3, DR=1, regWE=flagWE=1, instr_done=1.
- FETCH with mem_rdy low 3 cycles then high -> mem_req high 4 cycles, ldMDR/ldPC only in 4th, no bus_err.
- MEM_TIMEOUT=4, mem_rdy stuck 0 in LD1 -> bus_err pulse on 4th wait cycle, no regWE, next state FETCH0.
- BRz with Z=0/N=1 (IR=0x0405) -> ldPC=0. Same with Z=1 -> ldPC=1, selPC=01, selEAB2=10.
- STI (0xB602) with rdy delays of 2 -> MAR loaded twice, memWE with mem_req only in ST_W, instr_done once.
- Opcode 0xD000 -> ill_op pulse in DECODE, FETCH0 next. rst low during TRAP2 -> all outputs 0, FETCH0 after release.
